ex_muldiv_sequencer: RTL
========================

// Module: ex_muldiv_sequencer
// PURPOSE
//  Sequencer for a shared iterative RV32M multiply/divide resource beside the EX-stage ALU.
//  It accepts one M-extension operation from EX and runs a radix-2 shift-add or restoring-divide datapath.
//  While the operation is in flight it holds the EX stage via stall_out.
//  It returns one XLEN result with a single-cycle valid pulse for the EX/MEM register.
// PARAMETERS
//  XLEN   32  operand/result width; the iteration counter is $clog2(XLEN)+1 bits
// PORTS
//  clk           in   1     rising-edge clock, single clock domain
//  rst           in   1     synchronous, active-high reset
//  req_valid     in   1     EX holds an M-extension op (held high until result_valid)
//  req_ready     out  1     sequencer idle, request accepted this cycle if req_valid
//  req_funct3    in   3     000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  req_op_a      in   XLEN  rs1 value (already forwarded)
//  req_op_b      in   XLEN  rs2 value (already forwarded)
//  flush         in   1     branch/jump flush of EX; aborts any op
//  stall_out     out  1     hold IF/ID/EX pipeline registers
//  busy          out  1     state != IDLE
//  result_valid  out  1     one-cycle pulse, result valid
//  result        out  XLEN  final rd value
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, result=0, result_valid=0, busy=0, req_ready=1, stall_out=0.
//  - Accept: on a rising edge with req_valid & req_ready & !flush. Operands and funct3 are latched at acceptance.
//  - States:
//    - IDLE: on accept, normal op -> RUN; special case -> DONE.
//    - RUN: XLEN iterations, one per cycle. Counter counts XLEN-1 down to 0. At 0 -> DONE.
//    - DONE: result_valid=1 for exactly one cycle -> IDLE.
//  - Latency, measured from the accepting edge:
//    - Normal ops: result_valid high in cycle XLEN+1.
//    - Special cases: result_valid high in cycle 1.
//  - Multiply:
//    - Operands are converted to magnitudes per signedness; MULHSU treats op_a signed and op_b unsigned.
//    - 2*XLEN product accumulator; sign fix applied in DONE.
//    - MUL returns low XLEN bits; MULH/MULHSU/MULHU return high XLEN bits.
//  - Divide: restoring, operating on magnitudes. In DONE, quotient sign = sa^sb and remainder sign = sign of dividend.
//  - Special cases, detected in IDLE at accept:
//    - Divide by zero: DIV/DIVU -> all ones (0xFFFFFFFF); REM/REMU -> op_a.
//    - Signed overflow (op_a = 0x80000000, op_b = -1): DIV -> 0x80000000; REM -> 0.
//  - stall_out = req_valid & !result_valid. It is high in IDLE during the accept cycle and low in DONE, so EX advances exactly with the result.
//  - req_ready = (state==IDLE). No new request is accepted in DONE, so back-to-back ops have 1 idle gap minimum.
//  - flush: highest priority in every state. Next state = IDLE, no result_valid pulse, result unchanged. A flush coinciding with req_valid in IDLE blocks acceptance.
//  - rst mid-operation: same as the reset values above on the next edge; in-flight op discarded.
//  - result holds its last value until the next DONE.
// CONFIGURATION
//  MULDIV_FAST_MUL_EN defined:
//    - MUL/MULH/MULHSU/MULHU use a single-cycle combinational XLENxXLEN multiplier.
//    - Accept -> DONE directly; result_valid in cycle 1.
//    - Divides unchanged.
//  MULDIV_FAST_MUL_EN undefined: all ops are iterative as above; no hardware multiplier inferred.
// TESTING
//  1. MUL a=7, b=0xFFFFFFFD (-3) -> result 0xFFFFFFEB.
//     - Default build: result_valid at cycle 33, stall_out high cycles 0..32, exactly one pulse.
//     - With MULDIV_FAST_MUL_EN: result_valid at cycle 1.
//  2. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULH with the same operands -> 0x00000000. MULHSU a=-1, b=2 -> 0xFFFFFFFF.
//  3. Signed divide, a=-20 (0xFFFFFFEC), b=6:
//     - DIV -> 0xFFFFFFFD (-3); REM -> 0xFFFFFFFE (-2).
//     - DIVU 20/6 -> 3; REMU -> 2.
//     - Latency 33 for each op.
//  4. Special cases, each with result_valid at cycle 1:
//     - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
//     - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM with the same operands -> 0.
//  5. Flush and reset abort:
//     - Start DIVU, assert flush at cycle 10 -> IDLE at cycle 11, no result_valid, req_ready=1.
//     - Repeat with rst instead of flush -> same outcome plus reset values.
//  6. Back-to-back: DIVU 100/7 then MUL 3*4 (req_valid held) -> results 14 then 12, one pulse each; second accepted the cycle after first DONE.

Source files
------------

// File: rtl/ex_muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer beside the EX-stage ALU (radix-2 shift-add / restoring divide).
// Optional MULDIV_FAST_MUL_EN: multiplies complete through a single-cycle combinational multiplier.
module ex_muldiv_sequencer #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_op_a,
  input  logic [XLEN-1:0] req_op_b,
  input  logic            flush,
  output logic            stall_out,
  output logic            busy,
  output logic            result_valid,
  output logic [XLEN-1:0] result,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Handshake: a request is taken on a rising edge when req_valid & req_ready & !flush;
  // EX keeps req_valid high until the single-cycle result_valid pulse, then drops or replaces it.

  state_t            state;
  logic [CW-1:0]     count;
  logic [2:0]        f3_q;
  logic [XLEN-1:0]   mag_b_q;
  logic [2*XLEN-1:0] acc;
  logic              neg_lo_q;
  logic              neg_hi_q;

  // Request decode
  logic            is_div, a_signed, b_signed, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    is_div      = req_funct3[2];
    a_signed    = (req_funct3 == 3'b001) || (req_funct3 == 3'b010) ||
                  (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
    b_signed    = (req_funct3 == 3'b001) || (req_funct3 == 3'b100) || (req_funct3 == 3'b110);
    sa          = a_signed & req_op_a[XLEN-1];
    sb          = b_signed & req_op_b[XLEN-1];
    mag_a       = sa ? -req_op_a : req_op_a;
    mag_b       = sb ? -req_op_b : req_op_b;
    div_zero    = is_div && (req_op_b == '0);
    div_ovf     = is_div && !req_funct3[0] &&
                  (req_op_a == {1'b1, {(XLEN-1){1'b0}}}) && (req_op_b == '1);
    special     = div_zero | div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = req_funct3[1] ? req_op_a : '1;
    else if (div_ovf)
      special_res = req_funct3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
  end

`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod, fast_fix;
  logic [XLEN-1:0]   fast_res;
  always_comb begin
    fast_prod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    fast_fix  = (sa ^ sb) ? -fast_prod : fast_prod;
    fast_res  = (req_funct3[1:0] == 2'b00) ? fast_fix[XLEN-1:0] : fast_fix[2*XLEN-1:XLEN];
  end
`endif

  // One iteration step. Multiply: acc = {partial, multiplier}; divide: acc = {remainder, quotient}.
  logic [XLEN:0]     add_sum, shifted, diff;
  logic              ge;
  logic [XLEN-1:0]   rem_n;
  logic [2*XLEN-1:0] acc_next, prod;
  logic [XLEN-1:0]   quot_fix, rem_fix, final_res;

  always_comb begin
    add_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_b_q} : '0);
    shifted = acc[2*XLEN-1:XLEN-1];
    diff    = shifted - {1'b0, mag_b_q};
    ge      = !diff[XLEN];
    rem_n   = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    if (f3_q[2])
      acc_next = {rem_n, acc[XLEN-2:0], ge};
    else
      acc_next = {add_sum, acc[XLEN-1:1]};
    // Sign fix-up on the value produced by the final iteration
    prod     = neg_lo_q ? -acc_next : acc_next;
    quot_fix = neg_lo_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
    rem_fix  = neg_hi_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
    if (f3_q[2])
      final_res = f3_q[1] ? rem_fix : quot_fix;
    else
      final_res = (f3_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      f3_q         <= '0;
      mag_b_q      <= '0;
      acc          <= '0;
      neg_lo_q     <= 1'b0;
      neg_hi_q     <= 1'b0;
    end else if (flush) begin
      state        <= IDLE;
      count        <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (req_valid) begin
            f3_q     <= req_funct3;
            mag_b_q  <= mag_b;
            acc      <= {{XLEN{1'b0}}, mag_a};
            neg_lo_q <= sa ^ sb;
            neg_hi_q <= sa;
            if (special) begin
              result       <= special_res;
              result_valid <= 1'b1;
              state        <= DONE;
`ifdef MULDIV_FAST_MUL_EN
            end else if (!is_div) begin
              result       <= fast_res;
              result_valid <= 1'b1;
              state        <= DONE;
`endif
            end else begin
              count <= CW'(XLEN - 1);
              state <= RUN;
            end
          end
        end
        RUN: begin
          acc   <= acc_next;
          count <= count - 1'b1;
          if (count == '0) begin
            result       <= final_res;
            result_valid <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          result_valid <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign stall_out = req_valid & ~result_valid;
  assign dbg_state = state;

endmodule
